// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file, two combinational read ports, one write port, reg 0 hardwired to zero.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic              clk,
  input  logic              reset
);
  localparam int N = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs_q [N];
  logic [DATA_W-1:0] regs_d [N];
  // An if (not a ternary) so an unknown wr_en falls through as no write.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != '0) regs_d[wr_addr] = wr_data;
    regs_d[0] = '0;
  end
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  // Index 0 is decoded on the read side so it reads zero even before the first reset.
  assign rd_data1 = (rd_addr1 == '0) ? '0 : regs_q[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : regs_q[rd_addr2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: table-driven directed vectors, hand-written corner sequences and a random run against an array model.
module tb_reg_file;
  logic [31:0] rd_data1, rd_data2, wr_data;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic        wr_en, clk, reset;
  int vectors = 0;
  int miscompares = 0;

  reg_file dut (
    .rd_data1(rd_data1), .rd_data2(rd_data2), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_addr(wr_addr),
    .wr_en(wr_en), .clk(clk), .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [6];
  logic [31:0] model [32];

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd0,  32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 5'd31, 32'h12345678, 5'd5, 5'd31, 32'hDEADBEEF, 32'h12345678};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd31, 32'h0,        32'h12345678};
    tbl[3] = '{1'b1, 5'd7,  32'h00000011, 5'd7, 5'd5,  32'h00000011, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 5'd7,  32'h00000022, 5'd7, 5'd7,  32'h00000011, 32'h00000011};
    tbl[5] = '{1'b1, 5'd3,  32'hAAAA0000, 5'd3, 5'd7,  32'hAAAA0000, 32'h00000011};
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
      #1;
      check("reset_rd1", rd_data1, 32'h0);
      check("reset_rd2", rd_data2, 32'h0);
    end
    for (int i = 0; i < 6; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      step();
      wr_en = 1'b0; rd_addr1 = tbl[i].ra1; rd_addr2 = tbl[i].ra2;
      #1;
      check($sformatf("table%0d_rd1", i), rd_data1, tbl[i].exp1);
      check($sformatf("table%0d_rd2", i), rd_data2, tbl[i].exp2);
    end
    rd_addr2 = 5'd3; wr_addr = 5'd3; wr_data = 32'h5555FFFF; wr_en = 1'b1;
    #1;
    check("same_cycle_before", rd_data2, 32'hAAAA0000);
    step();
    wr_en = 1'b0;
    check("same_cycle_after", rd_data2, 32'h5555FFFF);
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000ABCD;
    step();
    reset = 1'b0; wr_en = 1'b0; rd_addr1 = 5'd9; rd_addr2 = 5'd5;
    #1;
    check("reset_priority_r9", rd_data1, 32'h0);
    check("reset_clears_r5", rd_data2, 32'h0);
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      wr_en = 1'($urandom);
      wr_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wr_data = $urandom;
      rd_addr1 = 5'($urandom);
      rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      #1;
      check("rand_rd1", rd_data1, rd_addr1 == 0 ? 32'h0 : model[rd_addr1]);
      check("rand_rd2", rd_data2, rd_addr2 == 0 ? 32'h0 : model[rd_addr2]);
      step();
      if (reset) for (int i = 0; i < 32; i++) model[i] = 32'h0;
      else if (wr_en && wr_addr != 0) model[wr_addr] = wr_data;
      check("rand_post_rd2", rd_data2, rd_addr2 == 0 ? 32'h0 : model[rd_addr2]);
    end
    reset = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(i);
      #1;
      check("final_rd1", rd_data1, i == 0 ? 32'h0 : model[i]);
      check("final_rd2", rd_data2, i == 0 ? 32'h0 : model[i]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
